tcp_session_handler_hls_deadlock_axis_monitor: RTL and testbench
================================================================

// Module: tcp_session_handler_hls_deadlock_axis_monitor
// PURPOSE
//  Parametrised deadlock monitor for one HLS dataflow instance. Ingests per-channel AXIS
//  block flags and per-sub-instance idle/block flags. Raises 'block' only after blocking
//  persists for a programmable number of consecutive cycles.
//  Captures a snapshot of the offending channels for debug readout.
//  Sits between the dataflow instance's stall taps and the top-level deadlock reporter.
//  With THRESHOLD=1 and STICKY=0, 'block' timing equals a plain registered OR of the flags.
// PARAMETERS
//  NUM_AXIS  5  number of AXIS channel block flags monitored (>=1)
//  NUM_INST  1  number of sub-instance idle/block flag pairs (>=1)
//  CNT_W     16 width of the stall counter and of the threshold input
//  STICKY    0  1: detection held until 'clear'; 0: detection drops when blocking stops
//  IDX_W     derived localparam = max(1,$clog2(NUM_AXIS))
// PORTS
//  clock            in   1         single clock
//  reset            in   1         asynchronous, active-high reset
//  axis_block_sigs  in   NUM_AXIS  1 = AXIS channel i is blocked this cycle
//  axis_mask        in   NUM_AXIS  1 = ignore channel i
//  inst_idle_sigs   in   NUM_INST  1 = sub-instance j is idle (its block flag is ignored)
//  inst_block_sigs  in   NUM_INST  1 = sub-instance j is blocked
//  threshold        in   CNT_W     consecutive blocked cycles needed; 0 is treated as 1
//  clear            in   1         synchronous clear of detection, counter and snapshots
//  block            out  1         deadlock detected (state DEADLOCK)
//  block_pending    out  1         blocking seen, threshold not yet reached (state COUNTING)
//  stall_cnt        out  CNT_W     consecutive blocked cycles, saturating at all-ones
//  snap_axis        out  NUM_AXIS  masked AXIS flags captured on entry to DEADLOCK
//  snap_inst        out  NUM_INST  effective inst flags captured on entry to DEADLOCK
//  first_idx        out  IDX_W     lowest set bit index of snap_axis; 0 if snap_axis==0
// BEHAVIOUR
//  - any_blk = |(axis_block_sigs & ~axis_mask) | |(inst_block_sigs & ~inst_idle_sigs).
//    This is combinational; no input registering.
//  - thr_eff = (threshold==0) ? 1 : threshold. Sampled every cycle; a mid-count change
//    compares against the new value.
//  - Reset (async assert, sync release): state=IDLE, every output 0.
//  - FSM, all transitions on posedge clock; outputs are registered:
//    IDLE:     any_blk & thr_eff==1 -> DEADLOCK, cnt=1; any_blk -> COUNTING, cnt=1;
//              otherwise stay, cnt=0.
//    COUNTING: !any_blk -> IDLE, cnt=0; any_blk & (cnt+1)>=thr_eff -> DEADLOCK, cnt++;
//              otherwise cnt++.
//    DEADLOCK: cnt++ while any_blk (total stall length).
//              STICKY=0: !any_blk -> IDLE, cnt=0.
//              STICKY=1: stay regardless of any_blk until clear; cnt freezes when !any_blk.
//  - Counter increments saturate at 2^CNT_W-1 and never wrap. (cnt+1) is compared at
//    CNT_W+1 bits.
//  - Snapshot: on every transition into DEADLOCK, snap_axis/snap_inst load the masked
//    flags of that same cycle, and first_idx is computed from them. Snapshots hold while
//    in DEADLOCK and are zeroed on exit to IDLE.
//  - Latency: block rises exactly thr_eff cycles after the first cycle of an unbroken
//    any_blk run (i.e. on the edge after the thr_eff-th blocked cycle).
//  - clear=1: next state IDLE, cnt=0, snapshots 0, from any state.
//    clear has priority over every transition in the same cycle, including would-be entry
//    to DEADLOCK. Blocking persisting after clear restarts counting from IDLE.
//  - block and block_pending are never both 1.
// TESTING
//  1. Defaults, threshold=1: axis_block_sigs=5'b00100 for 1 cycle -> block=1 for exactly
//     1 cycle, 1 cycle later; snap_axis=5'b00100, first_idx=2.
//  2. threshold=4: axis[0] high 3 cycles, low 1 cycle, high 4 cycles -> no block on first
//     run; block rises after 4th cycle of second run, stall_cnt=4, snap_axis=5'b00001.
//  3. axis_mask=5'b01000, axis[3] high 100 cycles -> block/pending stay 0.
//     Then mask=0 with threshold=3 -> block after 3 cycles.
//  4. inst_block=1 & inst_idle=1 for 50 cycles -> no block. Drop idle with threshold=2
//     -> block after 2 cycles, snap_inst=1.
//  5. STICKY=1, CNT_W=4: blocking 20 cycles then released -> block held, stall_cnt
//     saturates at 15. clear -> next cycle block=0, stall_cnt=0, snaps 0.
//     clear on detection cycle -> block never asserts that cycle.
//  6. reset asserted mid-COUNTING between clock edges -> all outputs 0 immediately.
//     Release with flags held -> counting restarts from 1.

Source files
------------

// File: rtl/tcp_session_handler_hls_deadlock_axis_monitor.sv
// ---------------------------------------------------------------------------
// tcp_session_handler_hls_deadlock_axis_monitor
//
// Deadlock monitor for one HLS dataflow instance. Watches the per-channel AXIS
// block flags and the per-sub-instance idle/block flags. 'block' is raised only
// after blocking has persisted for a programmable number of consecutive cycles.
// On entry to the deadlock state the offending flags are captured for debug
// readout.
//
// Ports
//   clock            single clock
//   reset            asynchronous, active-high reset
//   axis_block_sigs  [NUM_AXIS]  1 = AXIS channel i blocked this cycle
//   axis_mask        [NUM_AXIS]  1 = ignore channel i
//   inst_idle_sigs   [NUM_INST]  1 = sub-instance j idle (its block flag ignored)
//   inst_block_sigs  [NUM_INST]  1 = sub-instance j blocked
//   threshold        [CNT_W]     consecutive blocked cycles needed (0 acts as 1)
//   clear                        synchronous clear of detection, counter, snapshots
//   block                        deadlock detected
//   block_pending                blocking seen, threshold not yet reached
//   stall_cnt        [CNT_W]     consecutive blocked cycles, saturating
//   snap_axis        [NUM_AXIS]  masked AXIS flags captured on entry to deadlock
//   snap_inst        [NUM_INST]  effective inst flags captured on entry to deadlock
//   first_idx        [IDX_W]     lowest set bit of snap_axis (0 if none)
// ---------------------------------------------------------------------------
module tcp_session_handler_hls_deadlock_axis_monitor #(
  parameter int NUM_AXIS = 5,
  parameter int NUM_INST = 1,
  parameter int CNT_W    = 16,
  parameter bit STICKY   = 1'b0,
  localparam int IDX_W   = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_AXIS-1:0] axis_mask,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  input  logic [CNT_W-1:0]    threshold,
  input  logic                clear,
  output logic                block,
  output logic                block_pending,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [NUM_AXIS-1:0] snap_axis,
  output logic [NUM_INST-1:0] snap_inst,
  output logic [IDX_W-1:0]    first_idx
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    DEADLOCK = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [NUM_AXIS-1:0] axis_eff;
  logic [NUM_INST-1:0] inst_eff;
  logic                any_blk;
  logic [CNT_W-1:0]    thr_eff;
  logic [CNT_W:0]      cnt_inc;
  logic [CNT_W-1:0]    cnt_sat;
  logic                thr_hit;
  logic [CNT_W-1:0]    cnt_n;
  logic                snap_load;

  // Lowest set bit index; scanning downward lets the last hit win.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_AXIS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = NUM_AXIS - 1; i >= 0; i--) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign axis_eff = axis_block_sigs & ~axis_mask;
  assign inst_eff = inst_block_sigs & ~inst_idle_sigs;
  assign any_blk  = (|axis_eff) | (|inst_eff);
  assign thr_eff  = (threshold == '0) ? CNT_W'(1) : threshold;

  // Extra bit keeps the threshold comparison correct when the counter is all-ones.
  assign cnt_inc  = {1'b0, stall_cnt} + (CNT_W+1)'(1);
  assign cnt_sat  = (&stall_cnt) ? stall_cnt : cnt_inc[CNT_W-1:0];
  assign thr_hit  = cnt_inc >= {1'b0, thr_eff};

  // NOTE: every variable assigned in this block gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    cnt_n   = stall_cnt;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (any_blk) begin
          cnt_n   = CNT_W'(1);
          state_n = (thr_eff == CNT_W'(1)) ? DEADLOCK : COUNTING;
        end
      end
      COUNTING: begin
        if (!any_blk) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_sat;
          if (thr_hit) state_n = DEADLOCK;
        end
      end
      DEADLOCK: begin
        if (any_blk) begin
          cnt_n = cnt_sat;
        end else if (!STICKY) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
        // Sticky mode: stay put and freeze the count while blocking is absent.
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Clear wins over everything, including a would-be entry to DEADLOCK.
    if (clear) begin
      state_n = IDLE;
      cnt_n   = '0;
    end
  end

  assign snap_load = (state != DEADLOCK) && (state_n == DEADLOCK);

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      block         <= 1'b0;
      block_pending <= 1'b0;
      stall_cnt     <= '0;
      snap_axis     <= '0;
      snap_inst     <= '0;
      first_idx     <= '0;
    end else begin
      state         <= state_n;
      block         <= (state_n == DEADLOCK);
      block_pending <= (state_n == COUNTING);
      stall_cnt     <= cnt_n;
      if (state_n == IDLE) begin
        snap_axis <= '0;
        snap_inst <= '0;
        first_idx <= '0;
      end else if (snap_load) begin
        snap_axis <= axis_eff;
        snap_inst <= inst_eff;
        first_idx <= lowest_set(axis_eff);
      end
    end
  end

endmodule

// File: tb/tb_tcp_session_handler_hls_deadlock_axis_monitor.sv
module tb_tcp_session_handler_hls_deadlock_axis_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  axis_block_sigs, axis_mask;
  logic [0:0]  inst_idle_sigs, inst_block_sigs;
  logic [15:0] threshold;
  logic        clear;
  logic        block, block_pending;
  logic [15:0] stall_cnt;
  logic [4:0]  snap_axis;
  logic [0:0]  snap_inst;
  logic [2:0]  first_idx;

  // Second instance: sticky mode with a narrow counter.
  logic [4:0]  s_axis;
  logic [3:0]  s_thr;
  logic        s_clear;
  logic        s_block, s_pending;
  logic [3:0]  s_cnt;
  logic [4:0]  s_snap_axis;
  logic [0:0]  s_snap_inst;
  logic [2:0]  s_first_idx;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  tcp_session_handler_hls_deadlock_axis_monitor dut (
    .clock(clock), .reset(reset),
    .axis_block_sigs(axis_block_sigs), .axis_mask(axis_mask),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .threshold(threshold), .clear(clear),
    .block(block), .block_pending(block_pending), .stall_cnt(stall_cnt),
    .snap_axis(snap_axis), .snap_inst(snap_inst), .first_idx(first_idx)
  );

  tcp_session_handler_hls_deadlock_axis_monitor #(
    .NUM_AXIS(5), .NUM_INST(1), .CNT_W(4), .STICKY(1'b1)
  ) dut_sticky (
    .clock(clock), .reset(reset),
    .axis_block_sigs(s_axis), .axis_mask(axis_mask),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .threshold(s_thr), .clear(s_clear),
    .block(s_block), .block_pending(s_pending), .stall_cnt(s_cnt),
    .snap_axis(s_snap_axis), .snap_inst(s_snap_inst), .first_idx(s_first_idx)
  );

  typedef struct {
    logic [4:0]  axis;
    logic [4:0]  mask;
    logic        ib;
    logic        ii;
    logic [15:0] thr;
    logic        clr;
    logic        e_block;
    logic        e_pend;
    logic [15:0] e_cnt;
    logic [4:0]  e_snap;
    logic        e_sinst;
    logic [2:0]  e_idx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] axis, input logic [4:0] mask,
                              input logic ib, input logic ii, input logic [15:0] thr,
                              input logic clr, input logic eb, input logic ep,
                              input logic [15:0] ecnt, input logic [4:0] esnap,
                              input logic esinst, input logic [2:0] eidx);
    vec_t v;
    v.axis = axis; v.mask = mask; v.ib = ib; v.ii = ii; v.thr = thr; v.clr = clr;
    v.e_block = eb; v.e_pend = ep; v.e_cnt = ecnt; v.e_snap = esnap;
    v.e_sinst = esinst; v.e_idx = eidx;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {5'd0, block, block_pending, stall_cnt, snap_axis, snap_inst, first_idx};
  endfunction

  function automatic logic [31:0] s_obs();
    return {17'd0, s_block, s_pending, s_cnt, s_snap_axis, s_snap_inst, s_first_idx};
  endfunction

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [4:0] axis, input logic [4:0] mask, input logic ib,
                       input logic ii, input logic [15:0] thr, input logic clr);
    @(negedge clock);
    axis_block_sigs = axis; axis_mask = mask;
    inst_block_sigs = ib;   inst_idle_sigs = ii;
    threshold = thr;        clear = clr;
  endtask

  initial begin
    logic seen;

    reset = 1'b1;
    axis_block_sigs = '0; axis_mask = '0; inst_idle_sigs = '0; inst_block_sigs = '0;
    threshold = 16'd1; clear = 1'b0;
    s_axis = '0; s_thr = 4'd1; s_clear = 1'b0;

    // Columns: axis, mask, inst_blk, inst_idle, thr, clr | block, pend, cnt, snap_axis, snap_inst, idx
    // Single blocked cycle with threshold 1
    tbl.push_back(mk(5'b00100, 5'b0, 0, 0, 16'd1, 0,  1, 0, 16'd1, 5'b00100, 0, 3'd2));
    tbl.push_back(mk(5'b00000, 5'b0, 0, 0, 16'd1, 0,  0, 0, 16'd0, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00000, 5'b0, 0, 0, 16'd1, 0,  0, 0, 16'd0, 5'b00000, 0, 3'd0));
    // Threshold 4: a 3-cycle run is not enough, a 4-cycle run is
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd4, 0,  0, 1, 16'd1, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd4, 0,  0, 1, 16'd2, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd4, 0,  0, 1, 16'd3, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00000, 5'b0, 0, 0, 16'd4, 0,  0, 0, 16'd0, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd4, 0,  0, 1, 16'd1, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd4, 0,  0, 1, 16'd2, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd4, 0,  0, 1, 16'd3, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd4, 0,  1, 0, 16'd4, 5'b00001, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd4, 0,  1, 0, 16'd5, 5'b00001, 0, 3'd0));
    tbl.push_back(mk(5'b00000, 5'b0, 0, 0, 16'd4, 0,  0, 0, 16'd0, 5'b00000, 0, 3'd0));
    // Threshold 0 behaves like 1; first_idx picks the lowest of two bits
    tbl.push_back(mk(5'b10010, 5'b0, 0, 0, 16'd0, 0,  1, 0, 16'd1, 5'b10010, 0, 3'd1));
    tbl.push_back(mk(5'b00000, 5'b0, 0, 0, 16'd0, 0,  0, 0, 16'd0, 5'b00000, 0, 3'd0));
    // Threshold lowered mid-count takes effect immediately
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd5, 0,  0, 1, 16'd1, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd5, 0,  0, 1, 16'd2, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd2, 0,  1, 0, 16'd3, 5'b00001, 0, 3'd0));
    tbl.push_back(mk(5'b00000, 5'b0, 0, 0, 16'd2, 0,  0, 0, 16'd0, 5'b00000, 0, 3'd0));
    // Clear beats entry to DEADLOCK, counting restarts, clear leaves DEADLOCK
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd2, 0,  0, 1, 16'd1, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd2, 1,  0, 0, 16'd0, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd2, 0,  0, 1, 16'd1, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd2, 0,  1, 0, 16'd2, 5'b00001, 0, 3'd0));
    tbl.push_back(mk(5'b00001, 5'b0, 0, 0, 16'd2, 1,  0, 0, 16'd0, 5'b00000, 0, 3'd0));
    tbl.push_back(mk(5'b00000, 5'b0, 0, 0, 16'd2, 0,  0, 0, 16'd0, 5'b00000, 0, 3'd0));
    // Masked bit is excluded from the snapshot
    tbl.push_back(mk(5'b01001, 5'b01000, 0, 0, 16'd1, 0,  1, 0, 16'd1, 5'b00001, 0, 3'd0));
    tbl.push_back(mk(5'b00000, 5'b00000, 0, 0, 16'd1, 0,  0, 0, 16'd0, 5'b00000, 0, 3'd0));
    // Sub-instance block alone triggers detection
    tbl.push_back(mk(5'b00000, 5'b0, 1, 0, 16'd1, 0,  1, 0, 16'd1, 5'b00000, 1, 3'd0));
    tbl.push_back(mk(5'b00000, 5'b0, 0, 0, 16'd1, 0,  0, 0, 16'd0, 5'b00000, 0, 3'd0));

    #12;
    check("reset_outputs", obs(), 32'd0);
    check("reset_outputs_sticky", s_obs(), 32'd0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].axis, tbl[i].mask, tbl[i].ib, tbl[i].ii, tbl[i].thr, tbl[i].clr);
      step();
      check($sformatf("vec%0d", i), obs(),
            {5'd0, tbl[i].e_block, tbl[i].e_pend, tbl[i].e_cnt, tbl[i].e_snap,
             tbl[i].e_sinst, tbl[i].e_idx});
    end

    // Masked channel blocked for 100 cycles never registers
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive(5'b01000, 5'b01000, 0, 0, 16'd3, 0);
      step();
      seen = seen | block | block_pending;
    end
    check("masked_100_quiet", {31'd0, seen}, 32'd0);
    drive(5'b01000, 5'b00000, 0, 0, 16'd3, 0); step();
    drive(5'b01000, 5'b00000, 0, 0, 16'd3, 0); step();
    check("unmasked_2_cycles", {30'd0, block, block_pending}, 32'd1);
    drive(5'b01000, 5'b00000, 0, 0, 16'd3, 0); step();
    check("unmasked_3_cycles", obs(), {5'd0, 1'b1, 1'b0, 16'd3, 5'b01000, 1'b0, 3'd3});
    drive(5'b00000, 5'b00000, 0, 0, 16'd3, 0); step();

    // Idle sub-instance blocked for 50 cycles is ignored
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      drive(5'b0, 5'b0, 1, 1, 16'd2, 0);
      step();
      seen = seen | block | block_pending;
    end
    check("idle_inst_quiet", {31'd0, seen}, 32'd0);
    drive(5'b0, 5'b0, 1, 0, 16'd2, 0); step();
    check("inst_pending", {30'd0, block, block_pending}, 32'd1);
    drive(5'b0, 5'b0, 1, 0, 16'd2, 0); step();
    check("inst_block", obs(), {5'd0, 1'b1, 1'b0, 16'd2, 5'b0, 1'b1, 3'd0});
    drive(5'b0, 5'b0, 0, 0, 16'd2, 0); step();

    // Sticky instance: saturation, hold after release, clear
    @(negedge clock); s_clear = 1'b1; s_axis = '0; s_thr = 4'd3;
    step();
    check("sticky_preclear", s_obs(), 32'd0);
    @(negedge clock); s_clear = 1'b0; s_axis = 5'b00001;
    for (int i = 0; i < 20; i++) step();
    check("sticky_saturated", s_obs(), {17'd0, 1'b1, 1'b0, 4'd15, 5'b00001, 1'b0, 3'd0});
    @(negedge clock); s_axis = '0;
    for (int i = 0; i < 5; i++) step();
    check("sticky_held", s_obs(), {17'd0, 1'b1, 1'b0, 4'd15, 5'b00001, 1'b0, 3'd0});
    @(negedge clock); s_clear = 1'b1;
    step();
    check("sticky_cleared", s_obs(), 32'd0);
    @(negedge clock); s_thr = 4'd1; s_axis = 5'b00100; s_clear = 1'b1;
    step();
    check("sticky_clear_on_detect", s_obs(), 32'd0);
    @(negedge clock); s_clear = 1'b0;
    step();
    check("sticky_after_clear", s_obs(), {17'd0, 1'b1, 1'b0, 4'd1, 5'b00100, 1'b0, 3'd2});
    @(negedge clock); s_axis = '0;

    // Asynchronous reset mid-count, then restart with flags held
    drive(5'b00001, 5'b0, 0, 0, 16'd10, 0); step();
    drive(5'b00001, 5'b0, 0, 0, 16'd10, 0); step();
    drive(5'b00001, 5'b0, 0, 0, 16'd10, 0); step();
    check("pre_reset_count", obs(), {5'd0, 1'b0, 1'b1, 16'd3, 5'b0, 1'b0, 3'd0});
    #2 reset = 1'b1;
    #1;
    check("async_reset_immediate", obs(), 32'd0);
    @(negedge clock); reset = 1'b0;
    step();
    check("restart_after_reset", obs(), {5'd0, 1'b0, 1'b1, 16'd1, 5'b0, 1'b0, 3'd0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
